// File: rtl/fx_invcdf_prep.sv
// fx_invcdf_prep: front stage of the inverse-CDF normal generator.
// Folds a uniform sample u to the lower tail p = min(u, 1-u), remembers the
// sign, and produces t = sqrt(-2 ln p) in fixed point for the rational-
// polynomial stage. One sample in flight, valid/ready on both sides.
module fx_invcdf_prep #(
    parameter int WIDTH    = 32,
    parameter int QFRAC    = 16,
    parameter int UWIDTH   = 32,
    parameter int LUT_BITS = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [UWIDTH-1:0] u,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [WIDTH-1:0]  t,
    output logic              negate
);

    localparam int RW         = WIDTH + QFRAC;       // radicand width
    localparam int QW         = RW / 2;              // root width
    localparam int SQRT_ITERS = QW;
    localparam int CW         = $clog2(SQRT_ITERS);
    localparam int LZW        = $clog2(UWIDTH);
    localparam int KW         = $clog2(UWIDTH + 1);
    localparam int RMW        = QW + 5;              // partial remainder, two's complement
    localparam int LUT_N      = 1 << LUT_BITS;
    localparam int LF         = 30;                  // working precision of the table builder

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FOLD = 3'd1;
    localparam logic [2:0] S_LOG  = 3'd2;
    localparam logic [2:0] S_SQRT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // round(ln(1 + i/2^LUT_BITS) * 2^QFRAC), built at elaboration from
    // ln(1+x) = 2*atanh(x/(2+x)); the series converges by >= 9x per term.
    function automatic logic [QFRAC-1:0] ln1p_fix(input int i);
        longint s, s2, pw, acc;
        s   = (longint'(i) <<< LF) / longint'(2 * LUT_N + i);
        s2  = (s * s) >>> LF;
        pw  = s;
        acc = 0;
        for (int j = 0; j < 24; j++) begin
            acc = acc + pw / longint'(2 * j + 1);
            pw  = (pw * s2) >>> LF;
        end
        acc = (2 * acc + (longint'(1) <<< (LF - QFRAC - 1))) >>> (LF - QFRAC);
        return acc[QFRAC-1:0];
    endfunction

    localparam logic [QFRAC-1:0] LN2_FIX = ln1p_fix(LUT_N);

    logic [QFRAC-1:0] lut [0:LUT_N];
    for (genvar g = 0; g <= LUT_N; g++) begin : g_lut
        assign lut[g] = ln1p_fix(g);
    end

    logic [2:0]        state_q, state_d;
    logic [UWIDTH-1:0] u_q, u_d;
    logic              neg_q, neg_d;
    logic [KW-1:0]     k_q, k_d;
    logic [UWIDTH-2:0] mfrac_q, mfrac_d;
    logic [RW-1:0]     rad_q, rad_d;
    logic [RMW-1:0]    rem_q, rem_d;
    logic [QW-1:0]     root_q, root_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  t_q, t_d;
    logic              vld_q, vld_d;

    // Fold stage: tail fold, zero clamp, leading-zero count, normalisation.
    logic [UWIDTH-1:0] p;
    logic [LZW-1:0]    f_lz;
    logic              f_neg;
    logic [KW-1:0]     f_k;
    logic [UWIDTH-2:0] f_mfrac;

    always_comb begin
        f_neg = ~u_q[UWIDTH-1];
        p     = f_neg ? u_q : (~u_q + 1'b1);
        if (p == '0) p = {{(UWIDTH-1){1'b0}}, 1'b1};
        f_lz  = '0;
        for (int b = 0; b < UWIDTH; b++)
            if (p[b]) f_lz = LZW'(UWIDTH - 1 - b);
        f_k     = KW'(f_lz) + KW'(1);
        f_mfrac = (UWIDTH-1)'(p << f_lz);
    end

    // Log stage: interpolated ln(m), then w = 2*(k*ln2 - ln m) in Q.QFRAC.
    logic [UWIDTH+QFRAC-2:0] mf_ext;
    logic [LUT_BITS:0]       idx_lo, idx_hi;
    logic [QFRAC-1:0]        fr, l_lo, l_hi, l_dif;
    logic [2*QFRAC-1:0]      prod;
    logic [QFRAC:0]          lnm;
    logic [WIDTH-1:0]        kl, w;

    always_comb begin
        mf_ext = {mfrac_q, {QFRAC{1'b0}}};
        idx_lo = {1'b0, LUT_BITS'(mfrac_q >> (UWIDTH - 1 - LUT_BITS))};
        idx_hi = idx_lo + 1'b1;
        fr     = QFRAC'(mf_ext >> (UWIDTH - 1 - LUT_BITS));
        l_lo   = lut[idx_lo];
        l_hi   = lut[idx_hi];
        l_dif  = l_hi - l_lo;
        prod   = (2*QFRAC)'(l_dif) * (2*QFRAC)'(fr);
        lnm    = (QFRAC+1)'(l_lo) + (QFRAC+1)'(prod >> QFRAC);
        kl     = WIDTH'(k_q) * WIDTH'(LN2_FIX);
        // k >= 1 and ln m < ln2, so the difference never goes negative
        w      = (kl - WIDTH'(lnm)) << 1;
    end

    // One non-restoring square-root step: consume two radicand bits, emit one root bit.
    logic [RMW-1:0] rsh, rnew;
    logic [QW-1:0]  s_root;

    always_comb begin
        rsh = RMW'({rem_q, rad_q[RW-1 -: 2]});
        if (rem_q[RMW-1]) rnew = rsh + RMW'({root_q, 2'b11});
        else              rnew = rsh - RMW'({root_q, 2'b01});
        s_root = QW'({root_q, ~rnew[RMW-1]});
    end

    // Sequencer: IDLE -> FOLD -> LOG -> SQRT x SQRT_ITERS -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        neg_d   = neg_q;
        k_d     = k_q;
        mfrac_d = mfrac_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        vld_d   = vld_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    u_d     = u;
                    state_d = S_FOLD;
                end
            end
            S_FOLD: begin
                neg_d   = f_neg;
                k_d     = f_k;
                mfrac_d = f_mfrac;
                state_d = S_LOG;
            end
            S_LOG: begin
                rad_d   = {w, {QFRAC{1'b0}}};
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = '0;
                state_d = S_SQRT;
            end
            S_SQRT: begin
                rad_d  = rad_q << 2;
                rem_d  = rnew;
                root_d = s_root;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(SQRT_ITERS - 1)) begin
                    t_d     = WIDTH'(s_root);
                    vld_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_in) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any sample in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            u_q     <= '0;
            neg_q   <= 1'b0;
            k_q     <= '0;
            mfrac_q <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            t_q     <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            neg_q   <= neg_d;
            k_q     <= k_d;
            mfrac_q <= mfrac_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            vld_q   <= vld_d;
        end
    end

    assign ready_out = (state_q == S_IDLE);
    assign valid_out = vld_q;
    assign t         = t_q;
    assign negate    = neg_q;

endmodule

// File: tb/tb_fx_invcdf_prep.sv
// Directed and randomised bench for fx_invcdf_prep at default parameters.
// Cycle 0 is the handshake cycle; valid_out must first be seen in cycle 27.
module tb_fx_invcdf_prep;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] u;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] t;
    logic        negate;

    int checks;
    int fails;

    fx_invcdf_prep dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .u         (u),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .t         (t),
        .negate    (negate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint got, input longint exp, input longint tol);
        longint d;
        checks++;
        d = got - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Double-precision reference for t and negate.
    function automatic longint model_t(input logic [31:0] uv, output logic neg);
        real p;
        if (!uv[31]) begin p = real'(uv); neg = 1'b1; end
        else begin p = 4294967296.0 - real'(uv); neg = 1'b0; end
        if (p == 0.0) p = 1.0;
        p = p / 4294967296.0;
        return $rtoi($sqrt(-2.0 * $ln(p)) * 65536.0 + 0.5);
    endfunction

    // Push one sample and pull its result; lat is the cycle index of first valid_out.
    task automatic run_sample(input logic [31:0] uv, input bit rnd_rdy,
                              output longint t_got, output logic n_got, output int lat);
        int     n;
        longint t_first;
        bit     seen;
        bit     done;
        t_got = 0; n_got = 1'b0; lat = 0; seen = 0; done = 0; t_first = 0;
        u = uv;
        valid_in = 1'b1;
        n = 0;
        while (!ready_out && n < 200) begin tick(); n++; end
        chk("accept", longint'(ready_out), 1, 0);
        tick();
        valid_in = 1'b0;
        u = $urandom();
        n = 1;
        while (!done && n < 200) begin
            if (rnd_rdy) ready_in = 1'($urandom_range(0, 1));
            if (valid_out && !seen) begin
                seen = 1;
                lat = n;
                t_first = longint'(t);
            end
            if (valid_out && ready_in) begin
                done = 1;
                t_got = longint'(t);
                n_got = negate;
            end else begin
                tick();
                n++;
            end
        end
        chk("out_seen", longint'(done), 1, 0);
        if (done) begin
            chk("hold_t", t_got, t_first, 0);
            tick();
            chk("vld_drop", longint'(valid_out), 0, 0);
        end
    endtask

    logic [31:0] dv_u [6] = '{32'h8000_0000, 32'h4000_0000, 32'hC000_0000,
                             32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    longint      dv_t [6] = '{77163, 109124, 109124, 436497, 436497, 436497};
    logic        dv_n [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    longint      tg, t0, texp;
    logic        ng, n0, nexp;
    int          lat, n, first_acc, second_acc, bad, extra;
    logic [31:0] uv;

    initial begin
        checks = 0; fails = 0;
        rst_n = 1'b1; valid_in = 1'b0; ready_in = 1'b1; u = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid_out", longint'(valid_out), 0, 0);
        chk("rst_t", longint'(t), 0, 0);
        chk("rst_negate", longint'(negate), 0, 0);
        chk("rst_ready_out", longint'(ready_out), 1, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Directed vectors: tail fold, u = 0.5, zero clamp, extremes.
        for (int i = 0; i < 6; i++) begin
            ready_in = 1'b1;
            run_sample(dv_u[i], 1'b0, tg, ng, lat);
            chk($sformatf("dir_lat u=%h", dv_u[i]), lat, 27, 0);
            chk($sformatf("dir_t u=%h", dv_u[i]), tg, dv_t[i], 4);
            chk($sformatf("dir_neg u=%h", dv_u[i]), longint'(ng), longint'(dv_n[i]), 0);
        end

        // Throughput with valid_in and ready_in held high.
        ready_in = 1'b1; u = 32'h8000_0000; valid_in = 1'b1;
        first_acc = -1; second_acc = -1;
        for (int i = 0; i < 90 && second_acc < 0; i++) begin
            if (ready_out) begin
                if (first_acc < 0) first_acc = i;
                else second_acc = i;
            end
            tick();
        end
        valid_in = 1'b0;
        chk("thru_period", longint'(second_acc - first_acc), 28, 0);
        n = 0;
        while (!ready_out && n < 100) begin tick(); n++; end
        chk("thru_drain", longint'(ready_out), 1, 0);

        // Backpressure in DONE, with a second valid_in that must be ignored.
        ready_in = 1'b0; u = 32'h4000_0000; valid_in = 1'b1;
        n = 0;
        while (!ready_out && n < 100) begin tick(); n++; end
        tick();
        valid_in = 1'b0;
        n = 1;
        while (!valid_out && n < 100) begin tick(); n++; end
        chk("bp_lat", longint'(n), 27, 0);
        t0 = longint'(t); n0 = negate;
        chk("bp_t", t0, 109124, 4);
        chk("bp_neg", longint'(n0), 1, 0);
        u = 32'hFFFF_FFFF; valid_in = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!valid_out || longint'(t) != t0 || negate != n0 || ready_out) bad++;
        end
        chk("bp_hold_bad_cycles", longint'(bad), 0, 0);
        valid_in = 1'b0; ready_in = 1'b1;
        tick();
        chk("bp_vld_drop", longint'(valid_out), 0, 0);
        chk("bp_ready_back", longint'(ready_out), 1, 0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_out) extra++;
        end
        chk("bp_no_extra_out", longint'(extra), 0, 0);

        // Reset in the middle of the square root.
        u = 32'h4000_0000; valid_in = 1'b1;
        n = 0;
        while (!ready_out && n < 100) begin tick(); n++; end
        tick();
        valid_in = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_out", longint'(valid_out), 0, 0);
        chk("mid_rst_t", longint'(t), 0, 0);
        chk("mid_rst_ready_out", longint'(ready_out), 1, 0);
        chk("mid_rst_negate", longint'(negate), 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        run_sample(32'h8000_0000, 1'b0, tg, ng, lat);
        chk("post_rst_lat", lat, 27, 0);
        chk("post_rst_t", tg, 77163, 4);
        chk("post_rst_neg", longint'(ng), 0, 0);

        // Random sweep with random backpressure, including deep-tail samples.
        for (int s = 0; s < 300; s++) begin
            uv = $urandom();
            if (s % 8 == 0) uv = uv >> $urandom_range(0, 31);
            if (s % 8 == 3) uv = ~(uv >> $urandom_range(0, 31));
            valid_in = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            texp = model_t(uv, nexp);
            run_sample(uv, 1'b1, tg, ng, lat);
            chk($sformatf("rnd_lat u=%h", uv), lat, 27, 0);
            chk($sformatf("rnd_t u=%h", uv), tg, texp, 4);
            chk($sformatf("rnd_neg u=%h", uv), longint'(ng), longint'(nexp), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
